// File: rtl/dcf77_pkg.sv
// Shared constants, state type and frame helpers for the DCF77 minute-frame decoder.
// Optional feature macro: DCF77_PARITY_CHECK_EN (enables P1/P2/P3 even-parity checking).
package dcf77_pkg;

    localparam int START_POS  = 20;
    localparam int MIN_LSB    = 21;
    localparam int P1_POS     = 28;
    localparam int HOUR_LSB   = 29;
    localparam int P2_POS     = 35;
    localparam int DAY_LSB    = 36;
    localparam int WDAY_LSB   = 42;
    localparam int MONTH_LSB  = 45;
    localparam int YEAR_LSB   = 50;
    localparam int P3_POS     = 58;
    localparam int FRAME_BITS = 59;

    localparam logic [9:0]  W_MIN_MS   = 10'd40;
    localparam logic [9:0]  W_ONE_MS   = 10'd140;
    localparam logic [9:0]  W_MAX_MS   = 10'd260;
    localparam logic [11:0] MARKER_MS  = 12'd1500;
    localparam logic [11:0] TIMEOUT_MS = 12'd2500;

    localparam int SEC_OFS   = 0;
    localparam int MIN_OFS   = 8;
    localparam int HOUR_OFS  = 16;
    localparam int DAY_OFS   = 24;
    localparam int MONTH_OFS = 32;
    localparam int YEAR_OFS  = 40;

    typedef enum logic {
        SYNC    = 1'b0,
        RECEIVE = 1'b1
    } dcf_state_e;

    function automatic logic bcd_ok(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    function automatic logic frame_ok(input logic [58:0] f, input logic [5:0] nbits, input logic err);
        logic [3:0] mu, hu, du, mou, yu, yt;
        logic [2:0] mt;
        logic [1:0] ht, dt;
        logic       mot;
        logic       ok;
        mu  = f[MIN_LSB +: 4];       mt  = f[MIN_LSB + 4 +: 3];
        hu  = f[HOUR_LSB +: 4];      ht  = f[HOUR_LSB + 4 +: 2];
        du  = f[DAY_LSB +: 4];       dt  = f[DAY_LSB + 4 +: 2];
        mou = f[MONTH_LSB +: 4];     mot = f[MONTH_LSB + 4];
        yu  = f[YEAR_LSB +: 4];      yt  = f[YEAR_LSB + 4 +: 4];
        ok = (nbits == 6'd59) && !err && !f[0] && f[START_POS];
        ok = ok && bcd_ok(mu) && bcd_ok(hu) && bcd_ok(du) && bcd_ok(mou) && bcd_ok(yu) && bcd_ok(yt);
        ok = ok && (mt <= 3'd5);
        ok = ok && ((ht < 2'd2) || ((ht == 2'd2) && (hu <= 4'd3)));
        ok = ok && ({dt, du} != 6'h00) && ((dt < 2'd3) || (du <= 4'd1));
        ok = ok && ({mot, mou} != 5'h00) && (!mot || (mou <= 4'd2));
`ifdef DCF77_PARITY_CHECK_EN
        // Even parity: each parity bit makes its group (including itself) XOR to zero
        ok = ok && !(^f[MIN_LSB +: 8]) && !(^f[HOUR_LSB +: 7]) && !(^f[DAY_LSB +: 23]);
`endif
        return ok;
    endfunction

    function automatic logic [47:0] frame_word(input logic [58:0] f);
        logic [47:0] w;
        w = 48'd0;
        w[MIN_OFS   +: 7] = f[MIN_LSB   +: 7];
        w[HOUR_OFS  +: 6] = f[HOUR_LSB  +: 6];
        w[DAY_OFS   +: 6] = f[DAY_LSB   +: 6];
        w[MONTH_OFS +: 5] = f[MONTH_LSB +: 5];
        w[YEAR_OFS  +: 8] = f[YEAR_LSB  +: 8];
        return w;
    endfunction

    function automatic logic [7:0] bcd_sec_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s >= 8'h59) begin
            r = 8'h59;
        end else if (s[3:0] >= 4'd9) begin
            r = {s[7:4] + 4'd1, 4'd0};
        end else begin
            r = s + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dcf77_pulse_timer.sv
// Synchronizes the DCF77 input, times pulse widths and rise intervals in ms,
// and emits registered bit / marker / timeout events.
module dcf77_pulse_timer
    import dcf77_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic qzt_clk,
    input  logic rst,
    input  logic dcf_in,
    output logic bit_valid,
    output logic bit_val,
    output logic bit_bad,
    output logic marker,
    output logic pulse_start,
    output logic timeout
);

    localparam int unsigned DIV = ((CLK_FREQ / 1000) > 0) ? (CLK_FREQ / 1000) : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic          meta_r, sync_r, prev_r, armed_r;
    logic [PW-1:0] pre_r;
    logic [9:0]    width_r;
    logic [11:0]   interval_r;
    logic          rise_s, fall_s, tick_s;

    assign rise_s = sync_r & ~prev_r;
    assign fall_s = ~sync_r & prev_r;
    assign tick_s = (pre_r == PRE_LAST);

    // Input synchronizer and edge-history flop
    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= dcf_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    // Millisecond prescaler
    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            pre_r <= {PW{1'b0}};
        end else if (tick_s) begin
            pre_r <= {PW{1'b0}};
        end else begin
            pre_r <= pre_r + PW'(1);
        end
    end

    // Width and interval counters; an edge clears them ahead of a coincident tick
    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            width_r    <= 10'd0;
            interval_r <= 12'd0;
            armed_r    <= 1'b0;
        end else begin
            if (rise_s) begin
                width_r <= 10'd0;
            end else if (tick_s && (width_r != 10'd1023)) begin
                width_r <= width_r + 10'd1;
            end else begin
                width_r <= width_r;
            end
            if (rise_s) begin
                interval_r <= 12'd0;
            end else if (tick_s && (interval_r != 12'd4095)) begin
                interval_r <= interval_r + 12'd1;
            end else begin
                interval_r <= interval_r;
            end
            // a fall is only meaningful once its rise has been seen
            if (rise_s) begin
                armed_r <= 1'b1;
            end else if (fall_s) begin
                armed_r <= 1'b0;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // Registered event classification
    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            bit_valid   <= 1'b0;
            bit_val     <= 1'b0;
            bit_bad     <= 1'b0;
            marker      <= 1'b0;
            pulse_start <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            bit_valid   <= fall_s & armed_r;
            bit_val     <= (width_r >= W_ONE_MS) && (width_r < W_MAX_MS);
            bit_bad     <= (width_r < W_MIN_MS) || (width_r >= W_MAX_MS);
            marker      <= rise_s && (interval_r >= MARKER_MS);
            pulse_start <= rise_s;
            timeout     <= (interval_r >= TIMEOUT_MS);
        end
    end

endmodule

// File: rtl/dcf77_frame_decoder.sv
// DCF77 minute-frame decoder: assembles and validates frames, publishes BCD time/date
// with a load strobe and keeps seconds running. Optional macro: DCF77_PARITY_CHECK_EN.
module dcf77_frame_decoder
    import dcf77_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic        qzt_clk,
    input  logic        rst,
    input  logic        dcf_in,
    output logic [47:0] parallelInput,
    output logic        flag_load,
    output logic        time_valid,
    output logic        frame_error,
    output logic [5:0]  bit_index
);

    logic        bit_valid_s, bit_val_s, bit_bad_s, marker_s, pulse_start_s, timeout_s;
    dcf_state_e  state_r, state_nx_s;
    logic [58:0] frame_r, frame_nx_s;
    logic        err_r, err_nx_s;
    logic [5:0]  idx_nx_s;
    logic [47:0] word_nx_s;
    logic        valid_nx_s, load_nx_s, ferr_nx_s;

    dcf77_pulse_timer #(.CLK_FREQ(CLK_FREQ)) u_timer (
        .qzt_clk     (qzt_clk),
        .rst         (rst),
        .dcf_in      (dcf_in),
        .bit_valid   (bit_valid_s),
        .bit_val     (bit_val_s),
        .bit_bad     (bit_bad_s),
        .marker      (marker_s),
        .pulse_start (pulse_start_s),
        .timeout     (timeout_s)
    );

    // Next-state, frame assembly and output computation
    always_comb begin
        state_nx_s = state_r;
        frame_nx_s = frame_r;
        idx_nx_s   = bit_index;
        err_nx_s   = err_r;
        word_nx_s  = parallelInput;
        valid_nx_s = time_valid;
        load_nx_s  = 1'b0;
        ferr_nx_s  = 1'b0;
        case (state_r)
            SYNC: begin
                if (marker_s) begin
                    state_nx_s = RECEIVE;
                    frame_nx_s = 59'd0;
                    idx_nx_s   = 6'd0;
                    err_nx_s   = 1'b0;
                end else begin
                    state_nx_s = SYNC;
                end
            end
            RECEIVE: begin
                if (timeout_s) begin
                    state_nx_s = SYNC;
                    valid_nx_s = 1'b0;
                end else if (marker_s) begin
                    if (frame_ok(frame_r, bit_index, err_r)) begin
                        word_nx_s  = frame_word(frame_r);
                        valid_nx_s = 1'b1;
                        load_nx_s  = 1'b1;
                    end else begin
                        ferr_nx_s  = 1'b1;
                    end
                    frame_nx_s = 59'd0;
                    idx_nx_s   = 6'd0;
                    err_nx_s   = 1'b0;
                end else if (bit_valid_s) begin
                    // LSB-first stream: after 59 shifts, frame bit n sits at index n
                    frame_nx_s = {bit_val_s, frame_r[58:1]};
                    idx_nx_s   = (bit_index == 6'd59) ? bit_index : bit_index + 6'd1;
                    err_nx_s   = err_r | bit_bad_s | (bit_index == 6'd59);
                end else if (pulse_start_s && time_valid) begin
                    word_nx_s[SEC_OFS +: 8] = bcd_sec_inc(parallelInput[SEC_OFS +: 8]);
                    load_nx_s  = 1'b1;
                end else begin
                    state_nx_s = RECEIVE;
                end
            end
            default: begin
                state_nx_s = SYNC;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            state_r       <= SYNC;
            frame_r       <= 59'd0;
            err_r         <= 1'b0;
            bit_index     <= 6'd0;
            parallelInput <= 48'd0;
            time_valid    <= 1'b0;
            flag_load     <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            frame_r       <= frame_nx_s;
            err_r         <= err_nx_s;
            bit_index     <= idx_nx_s;
            parallelInput <= word_nx_s;
            time_valid    <= valid_nx_s;
            flag_load     <= load_nx_s;
            frame_error   <= ferr_nx_s;
        end
    end

endmodule

// File: tb/tb_dcf77_frame_decoder.sv
// Scoreboard bench for dcf77_frame_decoder; one clock cycle equals one millisecond tick.
module tb_dcf77_frame_decoder;

    localparam int CLK_FREQ = 1000;

    logic        qzt_clk = 1'b0;
    logic        rst;
    logic        dcf_in;
    logic [47:0] parallelInput;
    logic        flag_load, time_valid, frame_error;
    logic [5:0]  bit_index;

    dcf77_frame_decoder #(.CLK_FREQ(CLK_FREQ)) dut (
        .qzt_clk       (qzt_clk),
        .rst           (rst),
        .dcf_in        (dcf_in),
        .parallelInput (parallelInput),
        .flag_load     (flag_load),
        .time_valid    (time_valid),
        .frame_error   (frame_error),
        .bit_index     (bit_index)
    );

    always #5 qzt_clk = ~qzt_clk;

    typedef struct packed {
        logic        is_err;
        logic [47:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic        m_sync, m_valid, m_pend_good;
    logic [47:0] m_word, m_pend_word;
    int          m_gap;
    logic [58:0] frame_a, frame_b, frame_bad20;

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h59) return s;
        if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
        return s + 8'd1;
    endfunction

    function automatic logic [58:0] build_frame(input logic [7:0] mi, input logic [7:0] hr,
                                                input logic [7:0] dy, input logic [7:0] mo,
                                                input logic [7:0] yr, input logic [2:0] wd);
        logic [58:0] f;
        f        = 59'd0;
        f[20]    = 1'b1;
        f[27:21] = mi[6:0];
        f[28]    = ^mi[6:0];
        f[34:29] = hr[5:0];
        f[35]    = ^hr[5:0];
        f[41:36] = dy[5:0];
        f[44:42] = wd;
        f[49:45] = mo[4:0];
        f[57:50] = yr;
        f[58]    = ^f[57:36];
        return f;
    endfunction

    // Scoreboard: every strobe must match the oldest pending expectation
    always @(negedge qzt_clk) begin : monitor
        exp_t e;
        if (!rst && (flag_load || frame_error)) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL strobe_unexpected: got load=%0b err=%0b word=%h, required no strobe",
                         flag_load, frame_error, parallelInput);
            end else begin
                e = exp_q.pop_front();
                if ((flag_load !== !e.is_err) || (frame_error !== e.is_err) || (parallelInput !== e.word)) begin
                    tests_failed++;
                    $display("FAIL strobe_match: got load=%0b err=%0b word=%h, required load=%0b err=%0b word=%h",
                             flag_load, frame_error, parallelInput, !e.is_err, e.is_err, e.word);
                end
            end
        end
    end

    task automatic rise_model();
        if (m_gap >= 2500) begin
            m_valid = 1'b0;
            m_sync  = 1'b1;
        end
        if (m_gap >= 1500) begin
            if (!m_sync) begin
                if (m_pend_good) begin
                    m_word  = m_pend_word;
                    m_valid = 1'b1;
                    exp_q.push_back({1'b0, m_pend_word});
                end else begin
                    exp_q.push_back({1'b1, m_word});
                end
            end
            m_sync = 1'b0;
        end else if (m_valid) begin
            m_word[7:0] = bcd_inc(m_word[7:0]);
            exp_q.push_back({1'b0, m_word});
        end
        m_gap = 0;
    endtask

    task automatic idle_ms(input int n);
        repeat (n) @(negedge qzt_clk);
        m_gap += n;
        if (m_gap >= 2500) begin
            m_valid = 1'b0;
            m_sync  = 1'b1;
        end
    endtask

    task automatic send_pulse(input int width, input int spacing);
        rise_model();
        dcf_in = 1'b1;
        repeat (width) @(negedge qzt_clk);
        dcf_in = 1'b0;
        repeat (spacing - width) @(negedge qzt_clk);
        m_gap = spacing;
    endtask

    task automatic send_frame(input logic [58:0] f, input int bad_pos);
        int w;
        for (int i = 0; i < 59; i++) begin
            w = (i == bad_pos) ? 300 : (f[i] ? 200 : 100);
            send_pulse(w, (i == 58) ? 1700 : w + 20);
        end
    endtask

    task automatic check_drained(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s: %0d expected strobes never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; dcf_in = 1'b0;
        m_sync = 1'b1; m_valid = 1'b0; m_word = 48'd0; m_gap = 0; m_pend_good = 1'b0; m_pend_word = 48'd0;
        repeat (3) @(negedge qzt_clk);
        rst = 1'b0;
        tests_run++;
        if ({parallelInput, flag_load, time_valid, frame_error, bit_index} !== 57'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got word=%h valid=%0b idx=%0d, required all zero", parallelInput, time_valid, bit_index);
        end
        idle_ms(3000);
        tests_run++;
        if ({parallelInput, time_valid, bit_index} !== 55'd0) begin
            tests_failed++;
            $display("FAIL idle_3s: got word=%h valid=%0b idx=%0d, required all zero", parallelInput, time_valid, bit_index);
        end
        check_drained("idle_strobes");
    endtask

    task automatic test_good_frame();
        frame_a = build_frame(8'h37, 8'h14, 8'h25, 8'h12, 8'h24, 3'd3);
        send_frame(frame_a, -1);
        m_pend_good = 1'b1; m_pend_word = 48'h24_12_25_14_37_00;
        send_pulse(100, 1000);
        check_drained("good_frame_strobe");
        tests_run++;
        if ((parallelInput !== 48'h24_12_25_14_37_00) || (time_valid !== 1'b1) || (bit_index !== 6'd1)) begin
            tests_failed++;
            $display("FAIL good_frame: got word=%h valid=%0b idx=%0d, required 241225143700 1 1", parallelInput, time_valid, bit_index);
        end
    endtask

    task automatic test_seconds();
        for (int i = 0; i < 5; i++) begin
            send_pulse(100, (i == 4) ? 1700 : 1000);
        end
        check_drained("seconds_strobes");
        tests_run++;
        if (parallelInput !== 48'h24_12_25_14_37_05) begin
            tests_failed++;
            $display("FAIL seconds_step: got %h, required 241225143705", parallelInput);
        end
    endtask

    task automatic test_bad_frames();
        frame_bad20 = frame_a;
        frame_bad20[20] = 1'b0;
        frame_b = build_frame(8'h38, 8'h14, 8'h25, 8'h12, 8'h24, 3'd3);
        frame_b[35] = ~frame_b[35];
        m_pend_good = 1'b0;
        send_frame(frame_bad20, -1);
        send_frame(frame_a, 10);
        send_frame(frame_b, -1);
`ifdef DCF77_PARITY_CHECK_EN
        m_pend_good = 1'b0;
`else
        m_pend_good = 1'b1;
`endif
        m_pend_word = 48'h24_12_25_14_38_00;
        send_pulse(100, 1000);
        check_drained("bad_frames_strobes");
        tests_run++;
`ifdef DCF77_PARITY_CHECK_EN
        if ((parallelInput !== 48'h24_12_25_14_37_59) || (time_valid !== 1'b1)) begin
            tests_failed++;
            $display("FAIL parity_reject: got word=%h valid=%0b, required 241225143759 1", parallelInput, time_valid);
        end
`else
        if ((parallelInput !== 48'h24_12_25_14_38_00) || (time_valid !== 1'b1)) begin
            tests_failed++;
            $display("FAIL parity_ignored: got word=%h valid=%0b, required 241225143800 1", parallelInput, time_valid);
        end
`endif
    endtask

    task automatic test_timeout();
        idle_ms(2600);
        check_drained("timeout_strobes");
        tests_run++;
        if ((time_valid !== 1'b0) || (parallelInput !== m_word)) begin
            tests_failed++;
            $display("FAIL timeout: got valid=%0b word=%h, required 0 %h", time_valid, parallelInput, m_word);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 4; i++) begin
            send_pulse(100, 120);
        end
        tests_run++;
        if (bit_index !== 6'd4) begin
            tests_failed++;
            $display("FAIL resync_bits: got idx=%0d, required 4", bit_index);
        end
        rise_model();
        dcf_in = 1'b1;
        repeat (50) @(negedge qzt_clk);
        rst = 1'b1;
        @(negedge qzt_clk);
        rst = 1'b0;
        exp_q.delete();
        m_sync = 1'b1; m_valid = 1'b0; m_word = 48'd0; m_gap = 0;
        tests_run++;
        if ({parallelInput, flag_load, time_valid, frame_error, bit_index} !== 57'd0) begin
            tests_failed++;
            $display("FAIL mid_frame_reset: got word=%h valid=%0b idx=%0d, required all zero", parallelInput, time_valid, bit_index);
        end
        repeat (50) @(negedge qzt_clk);
        dcf_in = 1'b0;
        idle_ms(500);
        check_drained("post_reset_strobes");
        tests_run++;
        if ({parallelInput, time_valid, bit_index} !== 55'd0) begin
            tests_failed++;
            $display("FAIL post_reset_fall: got word=%h valid=%0b idx=%0d, required all zero", parallelInput, time_valid, bit_index);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_seconds();
        test_bad_frames();
        test_timeout();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dcf77_frame_decoder.md
# dcf77_frame_decoder

Receives the demodulated DCF77 pulse stream, measures pulse widths and gaps on the quartz clock, assembles the 59-bit minute frame and publishes validated BCD time/date as a 48-bit parallel word with a one-cycle load strobe. It is the producer side of the `parallelInput`/`flag_load` interface consumed by the scrolling display loop register. Between frames it keeps the seconds field running from the received second pulses.

## Interface
- `CLK_FREQ`, 50_000_000: `qzt_clk` frequency in Hz; the prescaler divides by `CLK_FREQ/1000` to produce a 1 ms tick.
- `qzt_clk` input 1: the single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `dcf_in` input 1: asynchronous demodulated signal; high means carrier reduced (pulse active).
- `parallelInput` output 48: BCD fields, packed as follows:
  - [7:0] seconds, [15:8] minutes, [23:16] hours
  - [31:24] day, [39:32] month, [47:40] year
  - Unused high bits of each byte are 0.
- `flag_load` output 1: one-cycle strobe that fires whenever `parallelInput` changes.
- `time_valid` output 1: at least one good frame has been decoded and sync is not lost.
- `frame_error` output 1: one-cycle strobe when a frame is rejected.
- `bit_index` output 6: current second/bit position, 0–59.

## Operation
- Input path: 2-flop synchronizer, then edge detector (rise = pulse start, fall = pulse end).
- Width counter:
  - 10-bit ms counter, cleared at rise, saturates at 1023.
  - Classified at fall: 40–139 ms → 0, 140–259 ms → 1, any other value → bad bit.
- Interval counter:
  - 12-bit ms counter, cleared at rise, saturates at 4095.
  - At rise, a value ≥1500 ms means a minute marker (missing second 59).
- States:
  - SYNC: wait for a minute marker, then clear the shift register, set `bit_index` = 0 and go to RECEIVE.
  - RECEIVE:
    - Each classified bit is shifted into a 59-bit register and `bit_index` increments (saturates at 59).
    - A bad bit sets a sticky error flag.
  - On minute marker in RECEIVE: validate the frame, then stay in RECEIVE for the next frame.
  - No rise for >2500 ms (interval counter ≥2500): go to SYNC and clear `time_valid`.
- Frame validation (all must hold):
  - Exactly 59 bits received.
  - No bad bit.
  - bit0 = 0 and bit20 = 1.
  - Every BCD digit ≤ 9.
  - Minutes ≤ 59, hours ≤ 23, day 1–31, month 1–12.
- Frame fields:
  - Minutes = bits 21–27, hours = 29–34, day = 36–41, month = 45–49, year = 50–57 (LSB first).
  - Weekday (bits 42–44) is discarded.
- Good frame: load minutes/hours/day/month/year, set seconds = 00, set `time_valid`, pulse `flag_load`.
- Bad frame: pulse `frame_error`; `parallelInput` and `time_valid` are unchanged.
- Second stepping:
  - Applies to each non-marker rise while `time_valid` is set.
  - The seconds BCD increments (00→01…→59, clamped at 59; leap second ignored) and `flag_load` pulses.

## Timing
- Reset values: `parallelInput` = 0, `flag_load` = 0, `time_valid` = 0, `frame_error` = 0, `bit_index` = 0; state SYNC; all counters 0.
- Latency: outputs and strobes are registered 4 `qzt_clk` cycles after the raw `dcf_in` edge (2 sync + 1 detect + 1 register).
- At most one `flag_load` per rise; a marker rise never also steps the seconds.
- Boundary cases:
  - Marker while in SYNC: only starts reception; no validation, no strobe.
  - 60th bit before a marker: sticky error set; the frame is rejected at the marker.
  - Fall with no preceding rise (after reset mid-pulse): ignored.
  - `rst` asserted at any time wins over all events, and the next cycle is in reset state.
  - Prescaler tick and edge in the same cycle: the edge sees the counter value before the tick.

## Configuration
- `DCF77_PARITY_CHECK_EN` defined: three parities are checked, and any mismatch rejects the frame:
  - P1 (bit 28) over bits 21–27.
  - P2 (bit 35) over bits 29–34.
  - P3 (bit 58) over bits 36–57.
- Not defined: parity bits are shifted in but ignored; all other checks still apply.

## Structure
- Shared package `dcf77_pkg` holds:
  - Bit-position constants (MIN_LSB = 21, HOUR_LSB = 29, DAY_LSB = 36, MONTH_LSB = 45, YEAR_LSB = 50, P1/P2/P3).
  - Width thresholds (40, 140, 260 ms), the marker threshold (1500 ms) and the timeout (2500 ms).
  - The state enum (SYNC, RECEIVE).
  - Field offsets of the 48-bit output word.
- One natural sub-module: `dcf77_pulse_timer`, containing the synchronizer, edge detector, ms prescaler, width/interval counters and classifier. It outputs `bit_valid`, `bit_val`, `bit_bad`, `marker` and `timeout`.

## Test plan
- Reset then no input for 3 s → stays in SYNC; `time_valid` = 0; no strobes; all outputs 0.
- Marker, then a good frame encoding 14:37, 25.12.24, then marker → one `flag_load`; `parallelInput` = 0x24_12_25_14_37_00; `time_valid` = 1.
- After that frame, five 100 ms pulses at 1 s spacing → five `flag_load` strobes; seconds reads 0x05.
- Same frame with bit 20 = 0, or a 300 ms pulse → `frame_error` pulse; output keeps its previous value.
- Flip P2 (parity-check macro defined) → frame rejected; with the macro not defined → frame accepted.
- With `time_valid` = 1, stop pulses for 2.6 s → `time_valid` = 0 and state returns to SYNC; assert `rst` mid-frame → all outputs 0 on the next cycle.
